// File: rtl/boss_bullet_pool.sv
// Multi-slot boss bullet manager: periodic spawn below the boss, downward
// flight on tick, retire on screen exit or hit, plus a per-pixel lookup that
// reports the lowest-index live bullet under the scan position.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   tick              one-cycle movement/fire strobe
//   boss_x, boss_y    boss top-left position (y in biased space)
//   boss_exist        boss alive; low clears every bullet and the fire counter
//   x, y              scan pixel position
//   hit_valid/hit_idx kill request for one slot
//   bullet_en         scan pixel lies inside a live bullet (combinational)
//   bullet_idx        slot drawn at the scan pixel (combinational)
//   rom_addr          sprite ROM address col+row*BW (combinational)
//   active_mask       live bit per slot
//   fire_pulse        a bullet spawned (registered, one cycle)
//   drop_pulse        a spawn attempt found no free slot (registered, one cycle)
module boss_bullet_pool #(
  parameter int unsigned NUM_BULLETS = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned BW          = 20,
  parameter int unsigned BH          = 60,
  parameter int unsigned SPEED       = 1,
  parameter int unsigned FIRE_PERIOD = 120,
  parameter int unsigned OFFSET_X    = 54,
  parameter int unsigned OFFSET_Y    = 60,
  parameter int unsigned Y_BIAS      = 480,
  parameter int unsigned Y_LIMIT     = 960,
  parameter int unsigned ADDR_W      = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic [9:0]             boss_x,
  input  logic [9:0]             boss_y,
  input  logic                   boss_exist,
  input  logic [9:0]             x,
  input  logic [9:0]             y,
  input  logic                   hit_valid,
  input  logic [IDX_W-1:0]       hit_idx,
  output logic                   bullet_en,
  output logic [IDX_W-1:0]       bullet_idx,
  output logic [ADDR_W-1:0]      rom_addr,
  output logic [NUM_BULLETS-1:0] active_mask,
  output logic                   fire_pulse,
  output logic                   drop_pulse
);

  localparam int unsigned FC_W = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;

  logic [NUM_BULLETS-1:0] live;
  logic [9:0]             bx    [NUM_BULLETS];
  logic [9:0]             by    [NUM_BULLETS];
  logic [10:0]            moved [NUM_BULLETS];
  logic [FC_W-1:0]        fcnt;
  logic                   fire_now;
  logic                   free_found;
  logic [IDX_W-1:0]       free_idx;
  logic [10:0]            x11;
  logic [10:0]            y11;
  logic [10:0]            col;
  logic [10:0]            row;

  assign active_mask = live;
  assign fire_now    = tick && (fcnt == FC_W'(FIRE_PERIOD - 1));

  // Next position of every slot at 11 bits so the screen-exit test cannot wrap.
  always_comb begin
    for (int i = 0; i < NUM_BULLETS; i++) begin
      moved[i] = {1'b0, by[i]} + 11'(SPEED);
    end
  end

  // Lowest free slot, judged on the registered live bits only.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!live[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Slot state and fire counter.
  always_ff @(posedge clk) begin
    fire_pulse <= 1'b0;
    drop_pulse <= 1'b0;
    if (rst) begin
      live <= '0;
      fcnt <= '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        bx[i] <= '0;
        by[i] <= '0;
      end
    end else if (!boss_exist) begin
      live <= '0;
      fcnt <= '0;
    end else begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (live[i]) begin
          if (hit_valid && (hit_idx == IDX_W'(i))) begin
            live[i] <= 1'b0;
          end else if (tick) begin
            by[i] <= moved[i][9:0];
            if (moved[i] > 11'(Y_LIMIT)) live[i] <= 1'b0;
          end
        end
      end
      if (tick) begin
        if (fire_now) begin
          fcnt <= '0;
          // The chosen slot was dead at the start of the cycle, so nothing
          // above touches it and the spawn cannot collide with a hit or move.
          if (free_found) begin
            live[free_idx] <= 1'b1;
            bx[free_idx]   <= boss_x + 10'(OFFSET_X);
            by[free_idx]   <= boss_y + 10'(OFFSET_Y);
            fire_pulse     <= 1'b1;
          end else begin
            drop_pulse     <= 1'b1;
          end
        end else begin
          fcnt <= fcnt + FC_W'(1);
        end
      end
    end
  end

  assign x11 = {1'b0, x};
  assign y11 = {1'b0, y} + 11'(Y_BIAS);

  // Pixel lookup; scanning downward lets the lowest matching index win.
  always_comb begin
    bullet_en  = 1'b0;
    bullet_idx = '0;
    rom_addr   = '0;
    col        = '0;
    row        = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (live[i] &&
          (x11 >= {1'b0, bx[i]}) && (x11 < ({1'b0, bx[i]} + 11'(BW))) &&
          (y11 >= {1'b0, by[i]}) && (y11 < ({1'b0, by[i]} + 11'(BH)))) begin
        bullet_en  = 1'b1;
        bullet_idx = IDX_W'(i);
        col        = x11 - {1'b0, bx[i]};
        row        = y11 - {1'b0, by[i]};
        rom_addr   = ADDR_W'(32'(col) + 32'(row) * BW);
      end
    end
  end

endmodule

// File: tb/tb_boss_bullet_pool.sv
// Directed bench for boss_bullet_pool (4 slots, fire period 4, speed 1).
module tb_boss_bullet_pool;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [9:0]  boss_x;
  logic [9:0]  boss_y;
  logic        boss_exist;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        hit_valid;
  logic [1:0]  hit_idx;
  logic        bullet_en;
  logic [1:0]  bullet_idx;
  logic [10:0] rom_addr;
  logic [3:0]  active_mask;
  logic        fire_pulse;
  logic        drop_pulse;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  boss_bullet_pool #(
    .NUM_BULLETS(4), .IDX_W(2), .BW(20), .BH(60), .SPEED(1), .FIRE_PERIOD(4),
    .OFFSET_X(54), .OFFSET_Y(60), .Y_BIAS(480), .Y_LIMIT(960), .ADDR_W(11)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .boss_x(boss_x), .boss_y(boss_y),
    .boss_exist(boss_exist), .x(x), .y(y), .hit_valid(hit_valid),
    .hit_idx(hit_idx), .bullet_en(bullet_en), .bullet_idx(bullet_idx),
    .rom_addr(rom_addr), .active_mask(active_mask), .fire_pulse(fire_pulse),
    .drop_pulse(drop_pulse)
  );

  typedef struct {
    logic        rst;
    logic        tick;
    logic        be;
    logic        hv;
    logic [1:0]  hi;
    logic [9:0]  boy;
    logic [9:0]  px;
    logic [9:0]  py;
    logic        en;
    logic [1:0]  idx;
    logic [10:0] addr;
    logic [3:0]  mask;
    logic        fp;
    logic        dp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic t, logic be, logic hv, logic [1:0] hi,
                              logic [9:0] boy, logic [9:0] px, logic [9:0] py,
                              logic en, logic [1:0] idx, logic [10:0] addr,
                              logic [3:0] mask, logic fp, logic dp);
    vec_t v;
    v.rst = r; v.tick = t; v.be = be; v.hv = hv; v.hi = hi; v.boy = boy;
    v.px = px; v.py = py; v.en = en; v.idx = idx; v.addr = addr;
    v.mask = mask; v.fp = fp; v.dp = dp;
    return v;
  endfunction

  // Drive one cycle of inputs, then sample just after the active edge.
  task automatic drive(input vec_t v);
    rst = v.rst; tick = v.tick; boss_exist = v.be; hit_valid = v.hv;
    hit_idx = v.hi; boss_y = v.boy; x = v.px; y = v.py;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input string name, input vec_t v);
    drive(v);
    n_vec++;
    if (bullet_en !== v.en || bullet_idx !== v.idx || rom_addr !== v.addr ||
        active_mask !== v.mask || fire_pulse !== v.fp || drop_pulse !== v.dp) begin
      n_miss++;
      $display("FAIL %s: got en=%0d idx=%0d addr=%0d mask=%b fire=%0d drop=%0d, want en=%0d idx=%0d addr=%0d mask=%b fire=%0d drop=%0d",
               name, bullet_en, bullet_idx, rom_addr, active_mask, fire_pulse, drop_pulse,
               v.en, v.idx, v.addr, v.mask, v.fp, v.dp);
    end
  endtask

  initial begin
    int first_fire;
    boss_x = 10'd100;
    rst = 1'b1; tick = 1'b0; boss_exist = 1'b1; boss_y = 10'd440;
    x = '0; y = '0; hit_valid = 1'b0; hit_idx = '0;

    //            rst tk be hv hi boy  px   py   en idx addr mask     fp dp
    tbl.push_back(mk(1, 0, 1, 0, 0, 440,   0,   0, 0, 0,    0, 4'b0000, 0, 0)); // 0 reset
    tbl.push_back(mk(0, 1, 1, 0, 0, 440, 154,  20, 0, 0,    0, 4'b0000, 0, 0)); // 1
    tbl.push_back(mk(0, 1, 1, 0, 0, 440, 154,  20, 0, 0,    0, 4'b0000, 0, 0)); // 2
    tbl.push_back(mk(0, 1, 1, 0, 0, 440, 154,  20, 0, 0,    0, 4'b0000, 0, 0)); // 3
    tbl.push_back(mk(0, 1, 1, 0, 0, 440, 154,  20, 1, 0,    0, 4'b0001, 1, 0)); // 4 spawn s0 by=500
    tbl.push_back(mk(0, 1, 1, 0, 0, 440, 154,  20, 0, 0,    0, 4'b0001, 0, 0)); // 5 s0 moved to 501
    tbl.push_back(mk(0, 1, 1, 0, 0, 440, 154,  22, 1, 0,    0, 4'b0001, 0, 0)); // 6 by=502
    tbl.push_back(mk(0, 1, 1, 0, 0, 440, 173,  82, 1, 0, 1199, 4'b0001, 0, 0)); // 7 last pixel
    tbl.push_back(mk(0, 1, 1, 0, 0, 440, 154,  24, 1, 0,    0, 4'b0011, 1, 0)); // 8 overlap, s0 wins
    tbl.push_back(mk(0, 0, 1, 0, 0, 440, 174,  24, 0, 0,    0, 4'b0011, 0, 0)); // 9 x=bx+BW
    tbl.push_back(mk(0, 0, 1, 0, 0, 440, 160,  20, 1, 1,    6, 4'b0011, 0, 0)); // 10 only s1
    tbl.push_back(mk(0, 1, 1, 0, 0, 440, 160,  21, 1, 1,    6, 4'b0011, 0, 0)); // 11
    tbl.push_back(mk(0, 1, 1, 0, 0, 440, 154,  26, 1, 0,    0, 4'b0011, 0, 0)); // 12
    tbl.push_back(mk(0, 1, 1, 0, 0, 440,   0,   0, 0, 0,    0, 4'b0011, 0, 0)); // 13
    tbl.push_back(mk(0, 1, 1, 1, 0, 440, 154,  20, 1, 2,    0, 4'b0110, 1, 0)); // 14 hit s0 + spawn s2
    tbl.push_back(mk(0, 1, 1, 0, 0, 440,   0,   0, 0, 0,    0, 4'b0110, 0, 0)); // 15
    tbl.push_back(mk(0, 1, 1, 0, 0, 440,   0,   0, 0, 0,    0, 4'b0110, 0, 0)); // 16
    tbl.push_back(mk(0, 1, 1, 0, 0, 440,   0,   0, 0, 0,    0, 4'b0110, 0, 0)); // 17
    tbl.push_back(mk(0, 1, 1, 0, 0, 440, 154,  20, 1, 0,    0, 4'b0111, 1, 0)); // 18 reuse s0
    tbl.push_back(mk(0, 1, 1, 0, 0, 440,   0,   0, 0, 0,    0, 4'b0111, 0, 0)); // 19
    tbl.push_back(mk(0, 1, 1, 0, 0, 440,   0,   0, 0, 0,    0, 4'b0111, 0, 0)); // 20
    tbl.push_back(mk(0, 1, 1, 0, 0, 440,   0,   0, 0, 0,    0, 4'b0111, 0, 0)); // 21
    tbl.push_back(mk(0, 1, 1, 0, 0, 440, 154,  20, 1, 3,    0, 4'b1111, 1, 0)); // 22 spawn s3
    tbl.push_back(mk(0, 1, 1, 0, 0, 440,   0,   0, 0, 0,    0, 4'b1111, 0, 0)); // 23
    tbl.push_back(mk(0, 1, 1, 0, 0, 440,   0,   0, 0, 0,    0, 4'b1111, 0, 0)); // 24
    tbl.push_back(mk(0, 1, 1, 0, 0, 440,   0,   0, 0, 0,    0, 4'b1111, 0, 0)); // 25
    tbl.push_back(mk(0, 1, 1, 0, 0, 440,   0,   0, 0, 0,    0, 4'b1111, 0, 1)); // 26 pool full
    tbl.push_back(mk(0, 1, 0, 0, 0, 440, 154,  20, 0, 0,    0, 4'b0000, 0, 0)); // 27 boss gone, tick ignored
    tbl.push_back(mk(0, 1, 1, 0, 0, 899,   0,   0, 0, 0,    0, 4'b0000, 0, 0)); // 28
    tbl.push_back(mk(0, 1, 1, 0, 0, 899,   0,   0, 0, 0,    0, 4'b0000, 0, 0)); // 29
    tbl.push_back(mk(0, 1, 1, 0, 0, 899,   0,   0, 0, 0,    0, 4'b0000, 0, 0)); // 30
    tbl.push_back(mk(0, 1, 1, 0, 0, 899, 154, 479, 1, 0,    0, 4'b0001, 1, 0)); // 31 spawn by=959
    tbl.push_back(mk(0, 1, 1, 0, 0, 899, 154, 480, 1, 0,    0, 4'b0001, 0, 0)); // 32 by=960 stays
    tbl.push_back(mk(0, 1, 1, 0, 0, 899, 154, 480, 0, 0,    0, 4'b0000, 0, 0)); // 33 961 retires

    foreach (tbl[i]) apply($sformatf("row%0d", i), tbl[i]);

    // Refill three slots, then reset mid-flight while a tick is present.
    for (int k = 0; k < 9; k++) drive(mk(0, 1, 1, 0, 0, 440, 0, 0, 0, 0, 0, 0, 0, 0));
    apply("refill", mk(0, 1, 1, 0, 0, 440, 0, 0, 0, 0, 0, 4'b0111, 1, 0));
    apply("midrst", mk(1, 1, 1, 0, 0, 440, 0, 0, 0, 0, 0, 4'b0000, 0, 0));

    // First spawn must come on the FIRE_PERIOD-th tick after reset release.
    first_fire = 0;
    for (int k = 1; k <= 10; k++) begin
      drive(mk(0, 1, 1, 0, 0, 440, 0, 0, 0, 0, 0, 0, 0, 0));
      if (fire_pulse === 1'b1) begin
        first_fire = k;
        break;
      end
    end
    n_vec++;
    if (first_fire != 4) begin
      n_miss++;
      $display("FAIL first_fire_after_rst: got tick %0d, want tick 4", first_fire);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
